arrow_lane_scheduler: RTL and testbench

//  Sequences one player's 20-row arrow lane for the VGA arrow renderer.

---
 rtl/arrow_lane_scheduler.sv | 134 +++++++++++++
 tb/tb_arrow_lane_scheduler.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arrow_lane_scheduler.sv
// Per-player arrow lane sequencer: scrolls a sub-row offset each frame and, once per
// lane row, fetches the next chart code and shifts it into the top of the arrow array.
module arrow_lane_scheduler #(
  parameter int unsigned NUM_ROWS    = 20,
  parameter int unsigned CODE_W      = 3,
  parameter int unsigned ROW_PIXELS  = 64,
  parameter int unsigned SCROLL_STEP = 4,
  parameter int unsigned CHART_AW    = 10,
  localparam int unsigned OFS_W      = $clog2(ROW_PIXELS)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         run,
  input  logic                         frame_start,
  output logic                         chart_req,
  output logic [CHART_AW-1:0]          chart_addr,
  input  logic                         chart_valid,
  input  logic [CODE_W-1:0]            chart_data,
  output logic [NUM_ROWS*CODE_W-1:0]   arrow_array,
  output logic [OFS_W-1:0]             scroll_offset,
  output logic [CODE_W-1:0]            bottom_arrow,
  output logic                         row_shifted,
  output logic                         song_done,
  output logic                         overrun
);

  localparam logic [OFS_W:0] STEP   = (OFS_W+1)'(SCROLL_STEP);
  localparam logic [OFS_W:0] ROW_PX = (OFS_W+1)'(ROW_PIXELS);

  typedef enum logic [2:0] {IDLE, WAIT_FRAME, FETCH, SHIFT, DONE} state_t;

  state_t                       state;
  logic                         pending;
  logic                         end_seen;
  logic                         abort;
  logic [CODE_W-1:0]            code_q;

  logic [OFS_W:0]               nxt_offset;
  logic [NUM_ROWS*CODE_W-1:0]   shifted;
  logic [CODE_W-1:0]            fetched;
  logic                         frame_hit;
  logic                         lane_clear;

  assign bottom_arrow = arrow_array[(NUM_ROWS-1)*CODE_W +: CODE_W];

  // Every path into IDLE (and IDLE itself) shares one clearing branch so the lane,
  // offset, address and flags are already zero in the first IDLE cycle.
  always_comb begin
    nxt_offset = {1'b0, scroll_offset} + STEP;
    shifted    = {arrow_array[(NUM_ROWS-1)*CODE_W-1:0], code_q};
    fetched    = (end_seen || chart_data == '1) ? '0 : chart_data;
    frame_hit  = frame_start || pending;
    lane_clear = 1'b0;
    unique case (state)
      IDLE:                    lane_clear = 1'b1;
      WAIT_FRAME, SHIFT, DONE: lane_clear = !run;
      FETCH:                   lane_clear = chart_valid && (abort || !run);
      default:                 lane_clear = 1'b1;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      arrow_array   <= '0;
      scroll_offset <= '0;
      chart_addr    <= '0;
      chart_req     <= 1'b0;
      pending       <= 1'b0;
      end_seen      <= 1'b0;
      overrun       <= 1'b0;
      abort         <= 1'b0;
      code_q        <= '0;
      row_shifted   <= 1'b0;
      song_done     <= 1'b0;
    end else begin
      row_shifted <= 1'b0;
      if (lane_clear) begin
        state         <= (state == IDLE && run) ? WAIT_FRAME : IDLE;
        arrow_array   <= '0;
        scroll_offset <= '0;
        chart_addr    <= '0;
        chart_req     <= 1'b0;
        pending       <= 1'b0;
        end_seen      <= 1'b0;
        overrun       <= 1'b0;
        abort         <= 1'b0;
        code_q        <= '0;
        song_done     <= 1'b0;
      end else begin
        if ((state == FETCH || state == SHIFT) && frame_start) begin
          if (pending) overrun <= 1'b1;
          else         pending <= 1'b1;
        end
        unique case (state)
          WAIT_FRAME: begin
            if (frame_hit) begin
              pending <= pending && frame_start;
              if (nxt_offset < ROW_PX) begin
                scroll_offset <= nxt_offset[OFS_W-1:0];
              end else begin
                scroll_offset <= OFS_W'(nxt_offset - ROW_PX);
                chart_req     <= 1'b1;
                state         <= FETCH;
              end
            end
          end
          FETCH: begin
            if (!run) abort <= 1'b1;
            if (chart_valid) begin
              code_q    <= fetched;
              chart_req <= 1'b0;
              state     <= SHIFT;
              if (chart_data == '1) end_seen <= 1'b1;
            end
          end
          SHIFT: begin
            arrow_array <= shifted;
            row_shifted <= 1'b1;
            if (!end_seen) chart_addr <= chart_addr + 1'b1;
            if (end_seen && shifted == '0) begin
              state     <= DONE;
              song_done <= 1'b1;
            end else begin
              state <= WAIT_FRAME;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_arrow_lane_scheduler.sv
// Directed bench for arrow_lane_scheduler: stimulus pushes expected per-shift results
// into a scoreboard that a monitor drains on each row_shifted pulse.
module tb_arrow_lane_scheduler;

  localparam int unsigned NUM_ROWS    = 20;
  localparam int unsigned CODE_W      = 3;
  localparam int unsigned ROW_PIXELS  = 64;
  localparam int unsigned SCROLL_STEP = 4;
  localparam int unsigned CHART_AW    = 10;

  logic                        clock = 1'b0;
  logic                        reset = 1'b1;
  logic                        run = 1'b0;
  logic                        frame_start = 1'b0;
  logic                        chart_req;
  logic [CHART_AW-1:0]         chart_addr;
  logic                        chart_valid = 1'b0;
  logic [CODE_W-1:0]           chart_data = '0;
  logic [NUM_ROWS*CODE_W-1:0]  arrow_array;
  logic [5:0]                  scroll_offset;
  logic [CODE_W-1:0]           bottom_arrow;
  logic                        row_shifted;
  logic                        song_done;
  logic                        overrun;

  always #5 clock = ~clock;

  arrow_lane_scheduler #(
    .NUM_ROWS   (NUM_ROWS),
    .CODE_W     (CODE_W),
    .ROW_PIXELS (ROW_PIXELS),
    .SCROLL_STEP(SCROLL_STEP),
    .CHART_AW   (CHART_AW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .run          (run),
    .frame_start  (frame_start),
    .chart_req    (chart_req),
    .chart_addr   (chart_addr),
    .chart_valid  (chart_valid),
    .chart_data   (chart_data),
    .arrow_array  (arrow_array),
    .scroll_offset(scroll_offset),
    .bottom_arrow (bottom_arrow),
    .row_shifted  (row_shifted),
    .song_done    (song_done),
    .overrun      (overrun)
  );

  typedef struct packed {
    logic [2:0] row0;
    logic [9:0] addr;
    logic [2:0] bottom;
    logic [5:0] offset;
    logic       done;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;

  logic [2:0]  mem [0:1023];
  int unsigned valid_delay = 0;
  int unsigned wait_cnt = 0;
  bit          rand_mode = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({chart_req, chart_addr, arrow_array, scroll_offset, bottom_arrow,
                 row_shifted, song_done, overrun});
  endfunction

  // Chart memory responder: answers a request after valid_delay cycles.
  always @(negedge clock) begin
    if (rand_mode) begin
      chart_valid = 1'($urandom);
      chart_data  = 3'($urandom);
    end else if (chart_req && !chart_valid) begin
      if (wait_cnt >= valid_delay) begin
        chart_valid = 1'b1;
        chart_data  = mem[chart_addr];
      end else begin
        wait_cnt++;
      end
    end else begin
      chart_valid = 1'b0;
      chart_data  = '0;
      wait_cnt    = 0;
    end
  end

  always @(negedge clock) begin
    if (!reset && row_shifted) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_shift", 128'(1), 128'(0));
      end else begin
        mon_e = sb.pop_front();
        check("shift_row0",   128'(arrow_array[2:0]), 128'(mon_e.row0));
        check("shift_addr",   128'(chart_addr),       128'(mon_e.addr));
        check("shift_bottom", 128'(bottom_arrow),     128'(mon_e.bottom));
        check("shift_offset", 128'(scroll_offset),    128'(mon_e.offset));
        check("shift_done",   128'(song_done),        128'(mon_e.done));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    @(negedge clock);
    frame_start = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_pulse();
      @(negedge clock);
    end
  endtask

  task automatic wait_shift(input int budget, output int cycles);
    cycles = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clock);
      if (row_shifted) begin
        cycles = c;
        break;
      end
    end
    if (cycles < 0) check("shift_timeout", 128'(0), 128'(1));
  endtask

  task automatic push(input logic [2:0] row0, input logic [9:0] addr,
                      input logic [2:0] bottom, input logic done);
    exp_t e;
    e.row0 = row0; e.addr = addr; e.bottom = bottom; e.offset = 6'd0; e.done = done;
    sb.push_back(e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    logic [2:0] bot;
    for (int i = 0; i < 1024; i++) mem[i] = 3'd6;
    mem[0] = 3'd1; mem[1] = 3'd2; mem[2] = 3'd3;
    mem[3] = 3'd4; mem[4] = 3'd5; mem[5] = 3'd7;

    // 1: reset held with random inputs, then release with run=0
    rand_mode = 1'b1;
    repeat (8) begin
      @(negedge clock);
      run = 1'($urandom);
      frame_start = 1'($urandom);
      #1 check("reset_outputs", all_outs(), 128'(0));
    end
    run = 1'b0; frame_start = 1'b0; rand_mode = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    tick(3);
    check("idle_outputs", all_outs(), 128'(0));

    // 2: fifteen frames scroll, sixteenth triggers the first fetch
    run = 1'b1;
    tick(1);
    frames(15);
    check("offset_60", 128'(scroll_offset), 128'(60));
    check("no_req_60", 128'(chart_req), 128'(0));
    push(3'd1, 10'd1, 3'd0, 1'b0);
    frame_pulse();
    check("wrap_offset", 128'(scroll_offset), 128'(0));
    check("wrap_req", 128'(chart_req), 128'(1));
    check("wrap_addr", 128'(chart_addr), 128'(0));
    wait_shift(20, cyc);
    check("shift_latency", 128'(cyc), 128'(2));
    tick(1);
    check("row_shifted_pulse", 128'(row_shifted), 128'(0));
    check("array_first", 128'(arrow_array), 128'(1));

    // 3a: slow chart, one frame lost to the fetch is applied afterwards
    valid_delay = 10;
    frames(15);
    push(3'd2, 10'd2, 3'd0, 1'b0);
    frame_pulse();
    tick(3);
    frame_pulse();
    wait_shift(40, cyc);
    tick(1);
    check("pending_offset", 128'(scroll_offset), 128'(4));
    check("no_overrun", 128'(overrun), 128'(0));
    tick(3);
    check("pending_once", 128'(scroll_offset), 128'(4));

    // 3b: two frames during a fetch -> overrun, only one applied
    frames(14);
    push(3'd3, 10'd3, 3'd0, 1'b0);
    frame_pulse();
    tick(3);
    frame_pulse();
    tick(2);
    frame_pulse();
    wait_shift(40, cyc);
    tick(1);
    check("overrun_offset", 128'(scroll_offset), 128'(4));
    check("overrun_set", 128'(overrun), 128'(1));
    tick(3);
    check("overrun_one_frame", 128'(scroll_offset), 128'(4));

    // 4: end marker at addr 5, lane drains to DONE
    valid_delay = 0;
    frames(14);
    push(3'd4, 10'd4, 3'd0, 1'b0);
    frame_pulse();
    wait_shift(20, cyc);
    frames(15);
    push(3'd5, 10'd5, 3'd0, 1'b0);
    frame_pulse();
    wait_shift(20, cyc);
    frames(15);
    push(3'd0, 10'd5, 3'd0, 1'b0);
    frame_pulse();
    wait_shift(20, cyc);
    for (int k = 1; k <= 19; k++) begin
      bot = (k >= 14 && k <= 18) ? 3'(k - 13) : 3'd0;
      frames(15);
      push(3'd0, 10'd5, bot, k == 19);
      frame_pulse();
      wait_shift(20, cyc);
    end
    tick(1);
    frames(3);
    check("done_held", 128'(song_done), 128'(1));
    check("done_offset", 128'(scroll_offset), 128'(0));
    check("done_no_req", 128'(chart_req), 128'(0));
    check("done_array", 128'(arrow_array), 128'(0));
    run = 1'b0;
    tick(1);
    check("done_to_idle", all_outs(), 128'(0));

    // 5: reset mid-fetch, then restart from addr 0
    run = 1'b1;
    tick(1);
    valid_delay = 20;
    frames(15);
    frame_pulse();
    check("mid_fetch_req", 128'(chart_req), 128'(1));
    tick(3);
    reset = 1'b1;
    #1 check("async_reset", all_outs(), 128'(0));
    @(negedge clock);
    reset = 1'b0;
    valid_delay = 0;
    tick(1);
    frames(15);
    push(3'd1, 10'd1, 3'd0, 1'b0);
    frame_pulse();
    check("restart_addr", 128'(chart_addr), 128'(0));
    wait_shift(20, cyc);

    // 6: run dropped in WAIT_FRAME clears the lane
    tick(1);
    frames(2);
    check("pre_stop_offset", 128'(scroll_offset), 128'(8));
    run = 1'b0;
    tick(1);
    check("stop_array", 128'(arrow_array), 128'(0));
    check("stop_offset", 128'(scroll_offset), 128'(0));
    check("stop_addr", 128'(chart_addr), 128'(0));
    frame_pulse();
    tick(1);
    check("idle_ignores_frame", 128'(scroll_offset), 128'(0));

    check("sb_drained", 128'(sb.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
